instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the 4-stage pipeline: owns the program counter, drives the synchronous instruction ROM and presents one 32-bit instruction per cycle on the fetch/decode boundary register consumed by `instructionDecode` (its `inst` input). It absorbs the ROM's one-cycle read latency, holds the boundary on stall through a one-entry skid register, and redirects on taken branches by inserting bubbles encoded as `inst = 0`, which decode treats as no-operation.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `PC_STEP`, default 4: byte increment between sequential fetches.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global pipeline enable; low freezes the stage exactly like `stall`, and `branchTaken` is ignored.
- `stall`  in  1  hazard-unit hold; boundary register and PC hold.
- `branchTaken`  in  1  redirect request from execute, one-cycle pulse.
- `branchTarget`  in  32  redirect byte address, sampled when `branchTaken` is high.
- `imemAddr`  out  32  ROM address, equal to the internal fetch PC `pcF` (combinational from the register).
- `imemData`  in  32  ROM read data; `imemData` in cycle t+1 = mem[`imemAddr` in cycle t].
- `inst`  out  32  registered instruction to decode; 0 when not valid.
- `pcOut`  out  32  registered byte address of `inst`; 0 when not valid.
- `instValid`  out  1  registered; high when `inst` is a real fetched instruction.

## Operation
- Internal registers: `pcF` (address being issued), `pcD` (address whose data is on `imemData`), `skidInst`, `skidPc`, `skidValid`, `state` in {REFILL, RUN, HOLD}.
- `hold` = `stall` | !`en`. `redirect` = `branchTaken` & `en`. Priority: redirect > hold > advance.
- Redirect (any state): `pcF` <= `branchTarget`, `inst` <= 0, `pcOut` <= 0, `instValid` <= 0, `skidValid` <= 0, state <= REFILL.
- REFILL (`imemData` not valid for the boundary): on hold, all registers hold and the state stays REFILL. Otherwise `inst`/`pcOut`/`instValid` <= 0/0/0, `pcD` <= `pcF`, `pcF` <= `pcF` + `PC_STEP`, state <= RUN.
- RUN: on advance, `inst` <= `imemData`, `pcOut` <= `pcD`, `instValid` <= 1, `pcD` <= `pcF`, `pcF` <= `pcF` + `PC_STEP`. On hold, boundary outputs, `pcF` and `pcD` hold, `skidInst` <= `imemData`, `skidPc` <= `pcD`, `skidValid` <= 1, state <= HOLD.
- HOLD: while hold, everything holds (the skid is not overwritten). On release, `inst` <= `skidInst`, `pcOut` <= `skidPc`, `instValid` <= 1, `skidValid` <= 0, `pcD` <= `pcF`, `pcF` <= `pcF` + `PC_STEP`, state <= RUN.
- During hold `imemAddr` stays constant, so the ROM data for `pcF` is valid on the release cycle.
- PC arithmetic is 32-bit modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is silent.
- `branchTarget` is used unmodified; alignment is the producer's responsibility.

## Timing
- Reset (async, immediate): `pcF` = `pcD` = `RESET_PC`, `inst` = 0, `pcOut` = 0, `instValid` = 0, `skidValid` = 0, state = REFILL. `imemAddr` = `RESET_PC` while `rst` is high.
- After `rst` falls: edge 1 produces a bubble, and edge 2 presents mem[`RESET_PC`] with `instValid` = 1.
- Steady state: one instruction per cycle. Issue-to-`inst` latency is 2 edges.
- Redirect costs 2 bubble cycles. The edge after `branchTaken` drives a bubble, the next edge drives a bubble (REFILL), and the third edge presents mem[`branchTarget`].
- Stall of N cycles: `inst` is unchanged for N cycles. The edge after `stall` falls presents the next sequential instruction with no loss and no duplication.
- `branchTaken` and `stall` high together: the redirect is taken and the stall is ignored for that edge.
- Reset asserted mid-stall or mid-refill discards the skid contents and any pending target.

## Test plan
- Reset release, ROM mem[k] = 32'hA000_0000 + k (word index), `RESET_PC` = 0 -> `inst` sequence 0, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002; `pcOut` 0, 0, 4, 8; `instValid` 0, 1, 1, 1.
- Steady run, then `stall` held 3 cycles while `inst` = 32'hA000_0002 -> `inst` and `pcOut` = 8 hold for 3 cycles. The next edge gives 32'hA000_0003 / 12, then 32'hA000_0004 / 16; no skipped or repeated word.
- `branchTaken` pulse with `branchTarget` = 32'h40 -> two cycles of `inst` = 0 and `instValid` = 0, then 32'hA000_0010 / 32'h40, then 32'hA000_0011 / 32'h44.
- `branchTaken` and `stall` high in the same cycle during HOLD, `branchTarget` = 32'h80 -> skid discarded; bubbles, then 32'hA000_0020 / 32'h80.
- `en` = 0 for 2 cycles with `branchTaken` = 1 in one of them -> outputs frozen, branch ignored, sequential order resumes exactly.
- `rst` pulsed asynchronously in HOLD -> outputs go to 0 / 0 / 0 immediately, and fetch restarts from `RESET_PC` as in the first scenario.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: control inputs, instruction ROM port and fetch/decode boundary of the fetch stage
interface instruction_fetch_if;
    logic        en;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] inst;
    logic [31:0] pcOut;
    logic        instValid;
    modport master (
        input  en, stall, branchTaken, branchTarget, imemData,
        output imemAddr, inst, pcOut, instValid
    );
    modport slave (
        output en, stall, branchTaken, branchTarget, imemData,
        input  imemAddr, inst, pcOut, instValid
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and ROM driver; hides the one-cycle ROM latency, skids on stall, bubbles on redirect
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic               clk,
    input logic               rst,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {REFILL, RUN, HOLD} state_t;
    state_t      state;
    logic [31:0] pc_f, pc_d, skid_inst, skid_pc;
    logic        skid_valid, hold, redirect;
    assign hold         = bus.stall | !bus.en;
    assign redirect     = bus.branchTaken & bus.en;
    assign bus.imemAddr = pc_f;
    // skid_valid is set exactly while in HOLD, so it selects the skid on release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f          <= RESET_PC;
            pc_d          <= RESET_PC;
            skid_inst     <= '0;
            skid_pc       <= '0;
            skid_valid    <= 1'b0;
            bus.inst      <= '0;
            bus.pcOut     <= '0;
            bus.instValid <= 1'b0;
            state         <= REFILL;
        end else if (redirect) begin
            pc_f          <= bus.branchTarget;
            bus.inst      <= '0;
            bus.pcOut     <= '0;
            bus.instValid <= 1'b0;
            skid_valid    <= 1'b0;
            state         <= REFILL;
        end else if (!hold) begin
            bus.inst      <= skid_valid ? skid_inst : (state == RUN) ? bus.imemData : '0;
            bus.pcOut     <= skid_valid ? skid_pc : (state == RUN) ? pc_d : '0;
            bus.instValid <= state != REFILL;
            skid_valid    <= 1'b0;
            pc_d          <= pc_f;
            pc_f          <= pc_f + PC_STEP;
            state         <= RUN;
        end else if (state == RUN) begin
            skid_inst  <= bus.imemData;
            skid_pc    <= pc_d;
            skid_valid <= 1'b1;
            state      <= HOLD;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized scoreboard bench comparing the boundary stream against an instruction-stream model
module tb_instruction_fetch;
    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] STEP = 32'd4;
    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
        logic        v;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    instruction_fetch_if bus ();
    instruction_fetch #(.RESET_PC(RPC), .PC_STEP(STEP)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction
    always @(posedge clk) bus.imemData <= rom(bus.imemAddr);
    exp_t        sb[$];
    int          checks = 0, failures = 0;
    logic [31:0] ei = '0, ep = '0, nxt = RPC;
    logic        ev = 1'b0;
    int          bub = 1;
    // model: the boundary shows a program-order stream; bubbles pending after reset/redirect, holds freeze it
    task automatic step(input bit e, input bit s, input bit b, input logic [31:0] t);
        bus.en = e; bus.stall = s; bus.branchTaken = b; bus.branchTarget = t;
        if (rst) begin
            ei = '0; ep = '0; ev = 1'b0; nxt = RPC; bub = 1;
        end else if (b && e) begin
            ei = '0; ep = '0; ev = 1'b0; nxt = t; bub = 1;
        end else if (e && !s) begin
            if (bub > 0) begin
                ei = '0; ep = '0; ev = 1'b0; bub--;
            end else begin
                ei = rom(nxt); ep = nxt; ev = 1'b1; nxt = nxt + STEP;
            end
        end
        sb.push_back('{ei, ep, ev});
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 32'h0);
    endtask
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                checks++;
                if (bus.inst !== x.i || bus.pcOut !== x.p || bus.instValid !== x.v) begin
                    failures++;
                    $display("FAIL boundary t=%0t got inst=%h pc=%h v=%b want inst=%h pc=%h v=%b",
                             $time, bus.inst, bus.pcOut, bus.instValid, x.i, x.p, x.v);
                end
            end
        end
    end
    initial begin
        bus.en = 1; bus.stall = 0; bus.branchTaken = 0; bus.branchTarget = '0;
        @(negedge clk);
        step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h100);
        rst = 1'b0;
        run(4);
        repeat (3) step(1, 1, 0, 32'h0);
        run(2);
        step(1, 0, 1, 32'h40);
        run(4);
        step(1, 1, 0, 32'h0);
        step(1, 1, 1, 32'h80);
        run(4);
        step(0, 0, 1, 32'h200);
        step(0, 1, 0, 32'h0);
        run(3);
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.inst !== 0 || bus.pcOut !== 0 || bus.instValid !== 0 || bus.imemAddr !== RPC) begin
            failures++;
            $display("FAIL async_reset got inst=%h pc=%h v=%b addr=%h want 0/0/0 addr=%h",
                     bus.inst, bus.pcOut, bus.instValid, bus.imemAddr, RPC);
        end
        step(1, 0, 0, 32'h0);
        rst = 1'b0;
        run(4);
        step(1, 0, 1, 32'hFFFF_FFF8);
        run(5);
        step(1, 0, 1, 32'h300);
        step(1, 1, 0, 32'h0);
        run(3);
        for (int k = 0; k < 2000; k++) begin
            bit e, s, b;
            e = $urandom_range(0, 9) != 0;
            s = $urandom_range(0, 3) == 0;
            b = $urandom_range(0, 9) == 0;
            step(e, s, b, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        end
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
